// File: rtl/pss_generator.sv
// NR PSS generator: LFSR-based m-sequence with N_id_2 cyclic offset,
// streamed as BPSK IQ samples on an AXI-stream master.
module pss_generator #(
   parameter int OUT_DW    = 32,
   parameter int AMPLITUDE = 8192
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic [1:0]        N_id_2_i,
   output logic              busy_o,
   output logic              error_o,
   output logic [OUT_DW-1:0] m_axis_out_tdata,
   output logic              m_axis_out_tvalid,
   output logic              m_axis_out_tlast,
   input  logic              m_axis_out_tready
);

   localparam int HW = OUT_DW / 2;
   // bit i holds x(i) of the initial window x(0)..x(6)
   localparam logic [6:0] X_INIT = 7'b1110110;
   localparam logic signed [HW-1:0] AMP_P = HW'(AMPLITUDE);
   localparam logic signed [HW-1:0] AMP_N = -AMP_P;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADVANCE,
      S_EMIT
   } state_t;

   state_t            r_state;
   logic [6:0]        r_lfsr;
   logic [6:0]        r_cnt;
   logic [6:0]        r_off;
   logic              r_busy;
   logic              r_err;
   logic              r_tvalid;
   logic              r_tlast;
   logic [OUT_DW-1:0] r_tdata;

   logic [6:0] w_lfsr_nxt;
   logic [6:0] w_off;
   logic       w_hs;

   assign w_lfsr_nxt = {r_lfsr[4] ^ r_lfsr[0], r_lfsr[6:1]};
   assign w_hs       = r_tvalid & m_axis_out_tready;

   always_comb begin
      w_off = 7'd0;
      unique case (N_id_2_i)
         2'd1:    w_off = 7'd43;
         2'd2:    w_off = 7'd86;
         default: w_off = 7'd0;
      endcase
   end

   function automatic logic [OUT_DW-1:0] sym(input logic x);
      return {{HW{1'b0}}, (x ? AMP_N : AMP_P)};
   endfunction

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state  <= S_IDLE;
         r_lfsr   <= X_INIT;
         r_cnt    <= 7'd0;
         r_off    <= 7'd0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
      end else begin
         r_err <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_lfsr <= X_INIT;
               r_cnt  <= 7'd0;
               if (start_i) begin
                  if (N_id_2_i == 2'd3) begin
                     r_err <= 1'b1;
                  end else begin
                     r_busy <= 1'b1;
                     r_off  <= w_off;
                     if (w_off == 7'd0) begin
                        r_state  <= S_EMIT;
                        r_tvalid <= 1'b1;
                        r_tdata  <= sym(X_INIT[0]);
                        r_tlast  <= 1'b0;
                     end else begin
                        r_state <= S_ADVANCE;
                     end
                  end
               end
            end
            S_ADVANCE: begin
               r_lfsr <= w_lfsr_nxt;
               // the last step also presents x(offset) on the bus
               if (r_cnt == r_off - 7'd1) begin
                  r_cnt    <= 7'd0;
                  r_state  <= S_EMIT;
                  r_tvalid <= 1'b1;
                  r_tdata  <= sym(w_lfsr_nxt[0]);
                  r_tlast  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 7'd1;
               end
            end
            S_EMIT: begin
               if (w_hs) begin
                  if (r_cnt == 7'd126) begin
                     r_state  <= S_IDLE;
                     r_lfsr   <= X_INIT;
                     r_cnt    <= 7'd0;
                     r_busy   <= 1'b0;
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_tdata  <= '0;
                  end else begin
                     r_lfsr  <= w_lfsr_nxt;
                     r_cnt   <= r_cnt + 7'd1;
                     r_tdata <= sym(w_lfsr_nxt[0]);
                     r_tlast <= (r_cnt == 7'd125);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o            = r_busy;
   assign error_o           = r_err;
   assign m_axis_out_tdata  = r_tdata;
   assign m_axis_out_tvalid = r_tvalid;
   assign m_axis_out_tlast  = r_tlast;

endmodule

// File: tb/tb_pss_generator.sv
// Directed bench for pss_generator: latency, sequence content,
// backpressure, rejects, mid-run reset and back-to-back starts.
module tb_pss_generator;

   logic        clk_i;
   logic        reset_ni;
   logic        start_i;
   logic [1:0]  N_id_2_i;
   logic        busy_o;
   logic        error_o;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tlast;
   logic        tready;

   pss_generator #(
      .OUT_DW    (32),
      .AMPLITUDE (8192)
   ) dut (
      .clk_i             (clk_i),
      .reset_ni          (reset_ni),
      .start_i           (start_i),
      .N_id_2_i          (N_id_2_i),
      .busy_o            (busy_o),
      .error_o           (error_o),
      .m_axis_out_tdata  (tdata),
      .m_axis_out_tvalid (tvalid),
      .m_axis_out_tlast  (tlast),
      .m_axis_out_tready (tready)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int          nvec;
   int          nerr;
   int          xs [127];
   logic [31:0] cap_buf [127];
   logic [31:0] cap0 [127];
   logic [31:0] cap1 [127];
   logic [31:0] cap2 [127];
   logic [31:0] capr [127];

   function automatic logic [31:0] exp_td(input int nid, input int n);
      int idx;
      idx = (n + 43 * nid) % 127;
      return (xs[idx] != 0) ? 32'h0000E000 : 32'h00002000;
   endfunction

   // caller is at a negedge; returns at the negedge after the last handshake
   task automatic run_seq(input int nid, input bit rnd, input bit inject,
                          input int exp_lat);
      int   lat;
      int   ns;
      int   cyc;
      bit   pstall;
      logic [31:0] pdata;
      logic        plast;
      start_i  = 1'b1;
      N_id_2_i = 2'(nid);
      tready   = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      nvec++;
      if (busy_o !== 1'b1) begin
         nerr++;
         $display("FAIL busy_after_start nid=%0d got=%b want=1", nid, busy_o);
      end
      lat = 1;
      while (tvalid !== 1'b1 && lat < 200) begin
         @(negedge clk_i);
         lat++;
      end
      nvec++;
      if (lat !== exp_lat) begin
         nerr++;
         $display("FAIL latency nid=%0d got=%0d want=%0d", nid, lat, exp_lat);
         return;
      end
      ns = 0;
      cyc = 0;
      pstall = 1'b0;
      pdata = '0;
      plast = 1'b0;
      while (ns < 127 && cyc < 1500) begin
         if (pstall) begin
            nvec++;
            if (tvalid !== 1'b1 || tdata !== pdata || tlast !== plast) begin
               nerr++;
               $display("FAIL stall_hold n=%0d got=%b/%h/%b want=1/%h/%b",
                        ns, tvalid, tdata, tlast, pdata, plast);
            end
         end
         if (inject) begin
            nvec++;
            if (error_o !== 1'b0) begin
               nerr++;
               $display("FAIL busy_start_err n=%0d got=%b want=0", ns, error_o);
            end
         end
         start_i  = (inject && ns == 30) ? 1'b1 : 1'b0;
         N_id_2_i = start_i ? 2'd2 : 2'(nid);
         tready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tvalid === 1'b1 && tready) begin
            cap_buf[ns] = tdata;
            nvec++;
            if (tdata !== exp_td(nid, ns)) begin
               nerr++;
               $display("FAIL sample nid=%0d n=%0d got=%h want=%h",
                        nid, ns, tdata, exp_td(nid, ns));
            end
            nvec++;
            if (tlast !== (ns == 126)) begin
               nerr++;
               $display("FAIL tlast nid=%0d n=%0d got=%b want=%b",
                        nid, ns, tlast, (ns == 126));
            end
            ns++;
         end
         pstall = (tvalid === 1'b1) && !tready;
         pdata  = tdata;
         plast  = tlast;
         @(negedge clk_i);
         cyc++;
      end
      start_i = 1'b0;
      nvec++;
      if (ns !== 127) begin
         nerr++;
         $display("FAIL sample_count nid=%0d got=%0d want=127", nid, ns);
      end
      nvec++;
      if (tvalid !== 1'b0 || busy_o !== 1'b0) begin
         nerr++;
         $display("FAIL done_idle nid=%0d got=%b/%b want=0/0",
                  nid, tvalid, busy_o);
      end
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      start_i  = 1'b0;
      N_id_2_i = 2'd0;
      tready   = 1'b1;
      repeat (3) @(negedge clk_i);
      nvec++;
      if ({tdata, tvalid, tlast, busy_o, error_o} !== 36'h0) begin
         nerr++;
         $display("FAIL reset_vals got=%h/%b/%b/%b/%b want=0",
                  tdata, tvalid, tlast, busy_o, error_o);
      end
      reset_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      nvec++;
      if (tvalid !== 1'b0 || busy_o !== 1'b0) begin
         nerr++;
         $display("FAIL post_reset_idle got=%b/%b want=0/0", tvalid, busy_o);
      end
   endtask

   task automatic test_nid0();
      logic [15:0] hand [8];
      hand = '{16'h2000, 16'hE000, 16'hE000, 16'h2000,
               16'hE000, 16'hE000, 16'hE000, 16'hE000};
      run_seq(0, 1'b0, 1'b0, 1);
      cap0 = cap_buf;
      for (int i = 0; i < 8; i++) begin
         nvec++;
         if (cap0[i] !== {16'h0, hand[i]}) begin
            nerr++;
            $display("FAIL hand_sample n=%0d got=%h want=%h",
                     i, cap0[i], {16'h0, hand[i]});
         end
      end
   endtask

   task automatic test_offsets();
      int bad;
      run_seq(1, 1'b0, 1'b0, 44);
      cap1 = cap_buf;
      @(negedge clk_i);
      run_seq(2, 1'b0, 1'b0, 87);
      cap2 = cap_buf;
      bad = 0;
      for (int n = 0; n < 127; n++) begin
         if (cap1[n] !== cap0[(n + 43) % 127]) bad++;
         if (cap2[n] !== cap0[(n + 86) % 127]) bad++;
      end
      nvec++;
      if (bad != 0) begin
         nerr++;
         $display("FAIL cyclic_shift got=%0d mismatching want=0", bad);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      @(negedge clk_i);
      run_seq(0, 1'b1, 1'b0, 1);
      capr = cap_buf;
      bad = 0;
      for (int n = 0; n < 127; n++)
         if (capr[n] !== cap0[n]) bad++;
      nvec++;
      if (bad != 0) begin
         nerr++;
         $display("FAIL random_ready_stream got=%0d mismatching want=0", bad);
      end
   endtask

   task automatic test_error();
      @(negedge clk_i);
      start_i  = 1'b1;
      N_id_2_i = 2'd3;
      @(negedge clk_i);
      start_i = 1'b0;
      nvec++;
      if (error_o !== 1'b1 || busy_o !== 1'b0 || tvalid !== 1'b0) begin
         nerr++;
         $display("FAIL reject_pulse got=%b/%b/%b want=1/0/0",
                  error_o, busy_o, tvalid);
      end
      @(negedge clk_i);
      nvec++;
      if (error_o !== 1'b0) begin
         nerr++;
         $display("FAIL reject_width got=%b want=0", error_o);
      end
      repeat (5) @(negedge clk_i);
      nvec++;
      if (tvalid !== 1'b0 || busy_o !== 1'b0) begin
         nerr++;
         $display("FAIL reject_quiet got=%b/%b want=0/0", tvalid, busy_o);
      end
   endtask

   task automatic test_start_during_busy();
      @(negedge clk_i);
      run_seq(1, 1'b0, 1'b1, 44);
   endtask

   task automatic test_reset_mid();
      int hs;
      int cyc;
      @(negedge clk_i);
      start_i  = 1'b1;
      N_id_2_i = 2'd0;
      tready   = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      hs = 0;
      cyc = 0;
      while (hs < 60 && cyc < 300) begin
         if (tvalid === 1'b1) hs++;
         if (hs < 60) @(negedge clk_i);
         cyc++;
      end
      #2;
      reset_ni = 1'b0;
      #1;
      nvec++;
      if ({tdata, tvalid, tlast, busy_o, error_o} !== 36'h0) begin
         nerr++;
         $display("FAIL async_reset got=%h/%b/%b/%b/%b want=0",
                  tdata, tvalid, tlast, busy_o, error_o);
      end
      @(negedge clk_i);
      reset_ni = 1'b1;
      @(negedge clk_i);
      run_seq(0, 1'b0, 1'b0, 1);
      nvec++;
      if (cap_buf[0] !== 32'h00002000) begin
         nerr++;
         $display("FAIL restart_d0 got=%h want=00002000", cap_buf[0]);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk_i);
      run_seq(0, 1'b0, 1'b0, 1);
      run_seq(0, 1'b0, 1'b0, 1);
      run_seq(1, 1'b0, 1'b0, 44);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      xs[0] = 0; xs[1] = 1; xs[2] = 1; xs[3] = 0;
      xs[4] = 1; xs[5] = 1; xs[6] = 1;
      for (int i = 0; i < 120; i++)
         xs[i + 7] = xs[i + 4] ^ xs[i];
      test_reset();
      test_nid0();
      test_offsets();
      test_backpressure();
      test_error();
      test_start_during_busy();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
